mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_rr.sv | 22 ++
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RESP  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } arb_op_e;

    // Port 0 carries data accesses, port 1 instruction fetch
    localparam logic PORT_DATA  = 1'b0;
    localparam logic PORT_FETCH = 1'b1;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-requester round-robin picker; purely combinational.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic [1:0] pending_i,
    input  logic       last_i,
    output logic       gnt_valid_c,
    output logic       gnt_idx_c
);

    // On contention the port not served last wins; otherwise the lone requester
    always_comb begin
        gnt_valid_c = |pending_i;
        gnt_idx_c   = PORT_DATA;
        if (&pending_i) begin
            gnt_idx_c = ~last_i;
        end else if (pending_i[PORT_FETCH]) begin
            gnt_idx_c = PORT_FETCH;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a data port and a fetch port onto one single-port memory with a response timeout.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned BITSIZE = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   resetn_i,
    input  logic [2*BITSIZE-1:0]   core_addr_i,
    input  logic [2*BITSIZE-1:0]   core_data_i,
    output logic [2*BITSIZE-1:0]   core_data_o,
    input  logic [1:0]             core_read_i,
    input  logic [1:0]             core_write_i,
    output logic [1:0]             core_valid_o,
    output logic [1:0]             core_err_o,
    output logic [BITSIZE-1:0]     mem_addr_o,
    output logic [BITSIZE-1:0]     mem_data_o,
    input  logic [BITSIZE-1:0]     mem_data_i,
    output logic                   mem_read_o,
    output logic                   mem_write_o,
    input  logic                   mem_valid_i
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 2);

    arb_state_e            state_q, state_d;
    logic                  last_q, last_d;
    logic                  port_q, port_d;
    arb_op_e               op_q, op_d;
    logic [BITSIZE-1:0]    addr_q, addr_d;
    logic [BITSIZE-1:0]    wdata_q, wdata_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  rd_q, rd_d;
    logic                  wr_q, wr_d;
    logic [1:0]            valid_q, valid_d;
    logic [1:0]            err_q, err_d;
    logic [2*BITSIZE-1:0]  rdata_q, rdata_d;

    logic                  gnt_valid_c;
    logic                  gnt_idx_c;
    arb_op_e               gnt_op_c;
    logic                  timeout_c;
    logic [BITSIZE-1:0]    rsp_data_c;

    mem_arb_rr u_rr (
        .pending_i   (core_read_i | core_write_i),
        .last_i      (last_q),
        .gnt_valid_c (gnt_valid_c),
        .gnt_idx_c   (gnt_idx_c)
    );

    // Write takes priority when a port raises both read and write
    assign gnt_op_c   = core_write_i[gnt_idx_c] ? OP_WRITE : OP_READ;
    assign timeout_c  = (cnt_q == CNT_W'(TIMEOUT));
    // A timed-out read returns zero
    assign rsp_data_c = mem_valid_i ? mem_data_i : '0;

    // State register
    always_ff @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_valid_c) state_d = GRANT;
            GRANT:   if (mem_valid_i || timeout_c) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        last_d  = last_q;
        port_d  = port_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        valid_d = 2'b00;
        err_d   = 2'b00;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (gnt_valid_c) begin
                    last_d  = gnt_idx_c;
                    port_d  = gnt_idx_c;
                    op_d    = gnt_op_c;
                    addr_d  = gnt_idx_c ? core_addr_i[2*BITSIZE-1:BITSIZE] : core_addr_i[BITSIZE-1:0];
                    wdata_d = gnt_idx_c ? core_data_i[2*BITSIZE-1:BITSIZE] : core_data_i[BITSIZE-1:0];
                    cnt_d   = '0;
                    rd_d    = (gnt_op_c == OP_READ);
                    wr_d    = (gnt_op_c == OP_WRITE);
                end
            end
            GRANT: begin
                if (mem_valid_i || timeout_c) begin
                    valid_d[port_q] = 1'b1;
                    err_d[port_q]   = ~mem_valid_i;
                    if (op_q == OP_READ) begin
                        if (port_q == PORT_FETCH) begin
                            rdata_d[2*BITSIZE-1:BITSIZE] = rsp_data_c;
                        end else begin
                            rdata_d[BITSIZE-1:0] = rsp_data_c;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    rd_d  = (op_q == OP_READ);
                    wr_d  = (op_q == OP_WRITE);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset abandons any in-flight access
    always_ff @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) begin
            last_q  <= PORT_FETCH;
            port_q  <= PORT_DATA;
            op_q    <= OP_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            valid_q <= 2'b00;
            err_q   <= 2'b00;
            rdata_q <= '0;
        end else begin
            last_q  <= last_d;
            port_q  <= port_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign mem_addr_o   = addr_q;
    assign mem_data_o   = wdata_q;
    assign mem_read_o   = rd_q;
    assign mem_write_o  = wr_q;
    assign core_valid_o = valid_q;
    assign core_err_o   = err_q;
    assign core_data_o  = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, corner sequences, randomized run vs. reference model.
module tb_mem_arbiter;

    localparam int unsigned BW = 32;
    localparam int unsigned TO = 8;

    logic            clk = 1'b0;
    logic            resetn_i;
    logic [2*BW-1:0] core_addr_i;
    logic [2*BW-1:0] core_data_i;
    logic [2*BW-1:0] core_data_o;
    logic [1:0]      core_read_i;
    logic [1:0]      core_write_i;
    logic [1:0]      core_valid_o;
    logic [1:0]      core_err_o;
    logic [BW-1:0]   mem_addr_o;
    logic [BW-1:0]   mem_data_o;
    logic [BW-1:0]   mem_data_i;
    logic            mem_read_o;
    logic            mem_write_o;
    logic            mem_valid_i;

    int errors = 0;
    int checks = 0;

    mem_arbiter #(.BITSIZE(BW), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .resetn_i     (resetn_i),
        .core_addr_i  (core_addr_i),
        .core_data_i  (core_data_i),
        .core_data_o  (core_data_o),
        .core_read_i  (core_read_i),
        .core_write_i (core_write_i),
        .core_valid_o (core_valid_o),
        .core_err_o   (core_err_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_data_i   (mem_data_i),
        .mem_read_o   (mem_read_o),
        .mem_write_o  (mem_write_o),
        .mem_valid_i  (mem_valid_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One row = inputs applied before an edge, expected outputs after it
    typedef struct {
        logic [1:0]  rd;
        logic [1:0]  wr;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] d1;
        logic        mv;
        logic [31:0] md;
        logic        e_rd;
        logic        e_wr;
        logic [31:0] e_addr;
        logic [31:0] e_mdata;
        logic [1:0]  e_valid;
        logic [1:0]  e_err;
        logic [31:0] e_d0;
        logic [31:0] e_d1;
    } vec_t;

    vec_t vecs[16];

    // Reference model state (transaction level)
    int          m_phase;   // 0 free, 1 memory access, 2 reporting
    logic        m_port;
    logic        m_write;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    int          m_wait;
    logic        m_err;
    logic        m_last;
    logic [31:0] m_d [2];
    logic        starve;

    initial begin
        int          n;
        logic        got;
        logic        exp_port;
        int          pulses;
        logic [1:0]  pend;
        logic [1:0]  exp_v;
        logic [1:0]  exp_e;
        int          r;

        vecs[0]  = '{2'b01, 2'b00, 32'h100, 32'h0,   32'h0,  1'b0, 32'h0,        1'b1, 1'b0, 32'h100, 32'h0,  2'b00, 2'b00, 32'h0,        32'h0};
        vecs[1]  = '{2'b01, 2'b00, 32'h100, 32'h0,   32'h0,  1'b0, 32'h0,        1'b1, 1'b0, 32'h100, 32'h0,  2'b00, 2'b00, 32'h0,        32'h0};
        vecs[2]  = '{2'b01, 2'b00, 32'h100, 32'h0,   32'h0,  1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,   32'h0,  2'b01, 2'b00, 32'hDEADBEEF, 32'h0};
        vecs[3]  = '{2'b00, 2'b00, 32'h0,   32'h0,   32'h0,  1'b1, 32'h00000BAD, 1'b0, 1'b0, 32'h0,   32'h0,  2'b00, 2'b00, 32'hDEADBEEF, 32'h0};
        vecs[4]  = '{2'b10, 2'b00, 32'h0,   32'h300, 32'h0,  1'b0, 32'h0,        1'b1, 1'b0, 32'h300, 32'h0,  2'b00, 2'b00, 32'hDEADBEEF, 32'h0};
        vecs[5]  = '{2'b10, 2'b00, 32'h0,   32'h300, 32'h0,  1'b1, 32'hCAFE0001, 1'b0, 1'b0, 32'h0,   32'h0,  2'b10, 2'b00, 32'hDEADBEEF, 32'hCAFE0001};
        vecs[6]  = '{2'b00, 2'b00, 32'h0,   32'h0,   32'h0,  1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   32'h0,  2'b00, 2'b00, 32'hDEADBEEF, 32'hCAFE0001};
        vecs[7]  = '{2'b10, 2'b10, 32'h0,   32'h200, 32'h55, 1'b0, 32'h0,        1'b0, 1'b1, 32'h200, 32'h55, 2'b00, 2'b00, 32'hDEADBEEF, 32'hCAFE0001};
        vecs[8]  = '{2'b10, 2'b10, 32'h0,   32'h200, 32'h55, 1'b1, 32'h12345678, 1'b0, 1'b0, 32'h0,   32'h0,  2'b10, 2'b00, 32'hDEADBEEF, 32'hCAFE0001};
        vecs[9]  = '{2'b00, 2'b00, 32'h0,   32'h0,   32'h0,  1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0,   32'h0,  2'b00, 2'b00, 32'hDEADBEEF, 32'hCAFE0001};
        vecs[10] = '{2'b11, 2'b00, 32'h10,  32'h20,  32'h0,  1'b1, 32'h0,        1'b1, 1'b0, 32'h10,  32'h0,  2'b00, 2'b00, 32'hDEADBEEF, 32'hCAFE0001};
        vecs[11] = '{2'b11, 2'b00, 32'h10,  32'h20,  32'h0,  1'b1, 32'h11111111, 1'b0, 1'b0, 32'h0,   32'h0,  2'b01, 2'b00, 32'h11111111, 32'hCAFE0001};
        vecs[12] = '{2'b11, 2'b00, 32'h10,  32'h20,  32'h0,  1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   32'h0,  2'b00, 2'b00, 32'h11111111, 32'hCAFE0001};
        vecs[13] = '{2'b11, 2'b00, 32'h10,  32'h20,  32'h0,  1'b0, 32'h0,        1'b1, 1'b0, 32'h20,  32'h0,  2'b00, 2'b00, 32'h11111111, 32'hCAFE0001};
        vecs[14] = '{2'b11, 2'b00, 32'h10,  32'h20,  32'h0,  1'b1, 32'h22222222, 1'b0, 1'b0, 32'h0,   32'h0,  2'b10, 2'b00, 32'h11111111, 32'h22222222};
        vecs[15] = '{2'b00, 2'b00, 32'h0,   32'h0,   32'h0,  1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   32'h0,  2'b00, 2'b00, 32'h11111111, 32'h22222222};

        // Reset state
        resetn_i     = 1'b0;
        core_addr_i  = '0;
        core_data_i  = '0;
        core_read_i  = 2'b00;
        core_write_i = 2'b00;
        mem_data_i   = '0;
        mem_valid_i  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_valid", 64'(core_valid_o), 64'h0);
        check("reset_err",   64'(core_err_o),   64'h0);
        check("reset_data",  core_data_o,       64'h0);
        check("reset_rd",    64'(mem_read_o),   64'h0);
        check("reset_wr",    64'(mem_write_o),  64'h0);
        check("reset_addr",  64'(mem_addr_o),   64'h0);
        resetn_i = 1'b1;

        // Directed vector table
        for (int i = 0; i < 16; i++) begin
            core_read_i  = vecs[i].rd;
            core_write_i = vecs[i].wr;
            core_addr_i  = {vecs[i].a1, vecs[i].a0};
            core_data_i  = {vecs[i].d1, 32'h0};
            mem_valid_i  = vecs[i].mv;
            mem_data_i   = vecs[i].md;
            @(negedge clk);
            check($sformatf("vec%0d_rd", i),    64'(mem_read_o),   64'(vecs[i].e_rd));
            check($sformatf("vec%0d_wr", i),    64'(mem_write_o),  64'(vecs[i].e_wr));
            check($sformatf("vec%0d_valid", i), 64'(core_valid_o), 64'(vecs[i].e_valid));
            check($sformatf("vec%0d_err", i),   64'(core_err_o),   64'(vecs[i].e_err));
            check($sformatf("vec%0d_data", i),  core_data_o,       {vecs[i].e_d1, vecs[i].e_d0});
            if (vecs[i].e_rd || vecs[i].e_wr)
                check($sformatf("vec%0d_addr", i), 64'(mem_addr_o), 64'(vecs[i].e_addr));
            if (vecs[i].e_wr)
                check($sformatf("vec%0d_mdata", i), 64'(mem_data_o), 64'(vecs[i].e_mdata));
        end
        mem_valid_i = 1'b0;

        // Timeout: port 0 read never answered
        core_read_i = 2'b01;
        core_addr_i = {32'h0, 32'h400};
        @(negedge clk);
        check("to_grant_rd", 64'(mem_read_o), 64'h1);
        check("to_addr", 64'(mem_addr_o), 64'h400);
        n   = 0;
        got = 1'b0;
        while (n < 20 && !got) begin
            @(negedge clk);
            n++;
            if (core_valid_o[0]) got = 1'b1;
        end
        check("to_latency", 64'(n), 64'd9);
        check("to_valid", 64'(core_valid_o), 64'h1);
        check("to_err", 64'(core_err_o), 64'h1);
        check("to_data", core_data_o, {32'h22222222, 32'h0});
        check("to_rd_low", 64'(mem_read_o), 64'h0);
        core_read_i = 2'b00;
        @(negedge clk);
        check("to_err_pulse", 64'(core_err_o), 64'h0);

        // Asynchronous reset in the middle of a grant
        core_read_i = 2'b10;
        core_addr_i = {32'h500, 32'h0};
        @(negedge clk);
        check("rst_grant_rd", 64'(mem_read_o), 64'h1);
        #2 resetn_i = 1'b0;
        #1;
        check("rst_async_rd",   64'(mem_read_o),   64'h0);
        check("rst_async_addr", 64'(mem_addr_o),   64'h0);
        check("rst_async_data", core_data_o,       64'h0);
        check("rst_async_valid", 64'(core_valid_o), 64'h0);
        @(negedge clk);
        resetn_i    = 1'b1;
        core_addr_i = {32'h600, 32'h0};
        core_read_i = 2'b10;
        mem_valid_i = 1'b1;
        mem_data_i  = 32'hABCD0123;
        @(negedge clk);
        check("rst_fresh_rd",   64'(mem_read_o), 64'h1);
        check("rst_fresh_addr", 64'(mem_addr_o), 64'h600);
        @(negedge clk);
        check("rst_fresh_valid", 64'(core_valid_o), 64'h2);
        check("rst_fresh_data",  core_data_o, {32'hABCD0123, 32'h0});

        // Both ports held: grants must alternate starting with port 0
        core_read_i = 2'b11;
        core_addr_i = {32'h2000, 32'h1000};
        mem_valid_i = 1'b1;
        exp_port    = 1'b0;
        pulses      = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (core_valid_o != 2'b00) begin
                check("alt_port", 64'(core_valid_o), exp_port ? 64'h2 : 64'h1);
                exp_port = ~exp_port;
                pulses++;
            end
        end
        check("alt_pulses", 64'(pulses), 64'd6);
        core_read_i = 2'b00;
        mem_valid_i = 1'b0;

        // Randomized run against the reference model, from a clean reset
        @(negedge clk);
        resetn_i = 1'b0;
        @(negedge clk);
        resetn_i = 1'b1;
        m_phase  = 0;
        m_last   = 1'b1;
        m_d[0]   = '0;
        m_d[1]   = '0;
        m_port   = 1'b0;
        m_write  = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        m_wait   = 0;
        m_err    = 1'b0;
        starve   = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc > 0) begin
                @(negedge clk);
                exp_v = 2'b00;
                exp_e = 2'b00;
                if (m_phase == 2) begin
                    exp_v[m_port] = 1'b1;
                    exp_e[m_port] = m_err;
                end
                check("rnd_rd",    64'(mem_read_o),   64'(m_phase == 1 && !m_write));
                check("rnd_wr",    64'(mem_write_o),  64'(m_phase == 1 && m_write));
                check("rnd_valid", 64'(core_valid_o), 64'(exp_v));
                check("rnd_err",   64'(core_err_o),   64'(exp_e));
                check("rnd_data",  core_data_o,       {m_d[1], m_d[0]});
                if (m_phase == 1) check("rnd_addr", 64'(mem_addr_o), 64'(m_addr));
                if (m_phase == 1 && m_write) check("rnd_mdata", 64'(mem_data_o), 64'(m_wdata));
            end

            // Requesters: mostly hold, change on completion or at random (including withdrawal)
            for (int p = 0; p < 2; p++) begin
                if (core_valid_o[p] || $urandom_range(0, 3) == 0) begin
                    r = int'($urandom_range(0, 3));
                    core_read_i[p]  = (r == 1 || r == 3);
                    core_write_i[p] = (r == 2 || r == 3);
                    core_addr_i[p*BW +: BW] = $urandom;
                    core_data_i[p*BW +: BW] = $urandom;
                end
            end
            mem_data_i = $urandom;
            if (m_phase == 1)
                mem_valid_i = !starve && ($urandom_range(0, 2) == 0);
            else
                mem_valid_i = ($urandom_range(0, 3) == 0);

            // Model reaction to the coming edge
            if (m_phase == 0) begin
                pend = core_read_i | core_write_i;
                if (pend != 2'b00) begin
                    if (pend == 2'b11) m_port = ~m_last;
                    else               m_port = pend[1];
                    m_last  = m_port;
                    m_write = core_write_i[m_port];
                    m_addr  = core_addr_i[m_port*BW +: BW];
                    m_wdata = core_data_i[m_port*BW +: BW];
                    m_wait  = 0;
                    m_phase = 1;
                    starve  = ($urandom_range(0, 5) == 0);
                end
            end else if (m_phase == 1) begin
                if (mem_valid_i) begin
                    m_phase = 2;
                    m_err   = 1'b0;
                    if (!m_write) m_d[m_port] = mem_data_i;
                end else if (m_wait == int'(TO)) begin
                    m_phase = 2;
                    m_err   = 1'b1;
                    if (!m_write) m_d[m_port] = '0;
                end else begin
                    m_wait++;
                end
            end else begin
                m_phase = 0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
